// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit: one shift-add or restoring shift-subtract
// step per cycle, fixed WIDTH-cycle latency, result committed to HI/LO at the end.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             mt_hi,
   input  logic             mt_lo,
   input  logic [WIDTH-1:0] mt_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_CALC = 1'b1;

   logic [0:0]       r_state;
   logic [CW-1:0]    r_count;
   logic             r_is_mul;
   logic             r_neg_res;
   logic             r_neg_rem;
   logic             r_div0;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_done;

   // op[0]=0 selects the signed flavour (MULT/DIV); op[1]=1 selects divide.
   logic             w_rs_neg;
   logic             w_rt_neg;
   logic [WIDTH-1:0] w_rs_mag;
   logic [WIDTH-1:0] w_rt_mag;

   assign w_rs_neg = ~op[0] & rs_data[WIDTH-1];
   assign w_rt_neg = ~op[0] & rt_data[WIDTH-1];
   assign w_rs_mag = w_rs_neg ? -rs_data : rs_data;
   assign w_rt_mag = w_rt_neg ? -rt_data : rt_data;

   // Multiply step: r_acc holds the running upper half, r_q shifts the
   // multiplier out at the bottom while product bits enter at the top.
   logic [WIDTH-1:0] w_add;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_mul_acc;
   logic [WIDTH-1:0] w_mul_q;

   assign w_add     = r_q[0] ? r_b : '0;
   assign w_sum     = {1'b0, r_acc} + {1'b0, w_add};
   assign w_mul_acc = w_sum[WIDTH:1];
   assign w_mul_q   = {w_sum[0], r_q[WIDTH-1:1]};

   // Divide step: shift the next dividend bit into the partial remainder.
   // When the trial subtraction succeeds the true difference is below the
   // divisor, so the modular WIDTH-bit difference is exact.
   logic [WIDTH:0]   w_rem_sh;
   logic             w_ge;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_div_acc;
   logic [WIDTH-1:0] w_div_q;

   assign w_rem_sh  = {r_acc, r_q[WIDTH-1]};
   assign w_ge      = (w_rem_sh >= {1'b0, r_b});
   assign w_diff    = w_rem_sh[WIDTH-1:0] - r_b;
   assign w_div_acc = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
   assign w_div_q   = {r_q[WIDTH-2:0], w_ge};

   logic [WIDTH-1:0]   w_acc_nxt;
   logic [WIDTH-1:0]   w_q_nxt;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;
   logic [WIDTH-1:0]   w_res_hi;
   logic [WIDTH-1:0]   w_res_lo;
   logic               w_last;

   assign w_acc_nxt  = r_is_mul ? w_mul_acc : w_div_acc;
   assign w_q_nxt    = r_is_mul ? w_mul_q   : w_div_q;

   // A zero divisor naturally leaves the dividend as remainder; only the
   // quotient needs forcing, since sign correction would otherwise alter it.
   assign w_prod     = {w_acc_nxt, w_q_nxt};
   assign w_prod_fix = r_neg_res ? -w_prod : w_prod;
   assign w_quo      = r_div0 ? '1 : (r_neg_res ? -w_q_nxt : w_q_nxt);
   assign w_rem      = r_neg_rem ? -w_acc_nxt : w_acc_nxt;
   assign w_res_hi   = r_is_mul ? w_prod_fix[2*WIDTH-1:WIDTH] : w_rem;
   assign w_res_lo   = r_is_mul ? w_prod_fix[WIDTH-1:0]       : w_quo;
   assign w_last     = (r_count == CW'(WIDTH - 1));

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_count   <= '0;
         r_is_mul  <= 1'b0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_div0    <= 1'b0;
         r_acc     <= '0;
         r_q       <= '0;
         r_b       <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_is_mul  <= ~op[1];
                  r_neg_res <= w_rs_neg ^ w_rt_neg;
                  r_neg_rem <= w_rs_neg;
                  r_div0    <= op[1] & (rt_data == '0);
                  r_acc     <= '0;
                  r_q       <= op[1] ? w_rs_mag : w_rt_mag;
                  r_b       <= op[1] ? w_rt_mag : w_rs_mag;
                  r_count   <= '0;
                  r_state   <= S_CALC;
               end else begin
                  if (mt_hi) r_hi <= mt_data;
                  if (mt_lo) r_lo <= mt_data;
               end
            end
            S_CALC: begin
               r_acc   <= w_acc_nxt;
               r_q     <= w_q_nxt;
               r_count <= r_count + CW'(1);
               if (w_last) begin
                  r_hi    <= w_res_hi;
                  r_lo    <= w_res_lo;
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy = (r_state == S_CALC);
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus handshake, MT and reset sequences.
module tb_mult_div_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        mt_hi;
   logic        mt_lo;
   logic [31:0] mt_data;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t vecs[10];

   mult_div_unit #(.WIDTH(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .mt_hi   (mt_hi),
      .mt_lo   (mt_lo),
      .mt_data (mt_data),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Starts an op (caller sits between edges), optionally injects a stray
   // start (kind 1) or MTHI (kind 2) before edge `inj` of CALC, and returns
   // once done is seen or the cycle budget runs out.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int inj, input int kind, input string name);
      int          lat;
      logic        busy_ok;
      logic        held_ok;
      logic [31:0] hi_before;
      logic [31:0] lo_before;
      op      = o;
      rs_data = a;
      rt_data = b;
      start   = 1'b1;
      @(posedge clk); #1;
      check({name, " busy after start"}, 32'(busy), 32'd1);
      check({name, " done low after start"}, 32'(done), 32'd0);
      start     = 1'b0;
      rs_data   = $urandom;
      rt_data   = $urandom;
      hi_before = hi;
      lo_before = lo;
      lat       = 0;
      busy_ok   = 1'b1;
      held_ok   = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         if (n == inj && kind == 1) begin
            start   = 1'b1;
            op      = OP_DIVU;
            rs_data = 32'd100;
            rt_data = 32'd7;
         end
         if (n == inj && kind == 2) begin
            mt_hi   = 1'b1;
            mt_data = 32'h1234_5678;
         end
         @(posedge clk); #1;
         start = 1'b0;
         mt_hi = 1'b0;
         if (done) begin
            lat = n;
            break;
         end
         if (!busy) busy_ok = 1'b0;
         if (hi !== hi_before || lo !== lo_before) held_ok = 1'b0;
      end
      check({name, " latency"}, lat, 32'd32);
      check({name, " busy held"}, 32'(busy_ok), 32'd1);
      check({name, " hi/lo held during calc"}, 32'(held_ok), 32'd1);
      check({name, " busy low at done"}, 32'(busy), 32'd0);
   endtask

   initial begin
      vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[1] = '{OP_MULT,  32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
      vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
      vecs[4] = '{OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
      vecs[5] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
      vecs[6] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      vecs[7] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
      vecs[8] = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
      vecs[9] = '{OP_MULTU, 32'h1234_5678, 32'h10,        32'd1,         32'h2345_6780};

      rst     = 1'b1;
      start   = 1'b0;
      op      = 2'b00;
      rs_data = '0;
      rt_data = '0;
      mt_hi   = 1'b0;
      mt_lo   = 1'b0;
      mt_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset hi", hi, 32'd0);
      check("reset lo", lo, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Each call starts in the previous done cycle: back-to-back acceptance.
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 0, $sformatf("vec%0d", i));
         check($sformatf("vec%0d hi", i), hi, vecs[i].exp_hi);
         check($sformatf("vec%0d lo", i), lo, vecs[i].exp_lo);
      end
      @(posedge clk); #1;
      check("done one-cycle pulse", 32'(done), 32'd0);

      run_op(OP_MULTU, 32'd6, 32'd7, 5, 1, "stray start");
      check("stray start hi", hi, 32'd0);
      check("stray start lo", lo, 32'd42);
      @(posedge clk); #1;
      check("stray start not queued", 32'(busy), 32'd0);

      run_op(OP_MULTU, 32'd3, 32'd5, 4, 2, "mthi busy");
      check("mthi busy hi", hi, 32'd0);
      check("mthi busy lo", lo, 32'd15);

      mt_hi   = 1'b1;
      mt_data = 32'h1234_5678;
      @(posedge clk); #1;
      mt_hi = 1'b0;
      check("mthi idle hi", hi, 32'h1234_5678);
      check("mthi idle lo untouched", lo, 32'd15);
      mt_hi   = 1'b1;
      mt_lo   = 1'b1;
      mt_data = 32'hCAFE_F00D;
      @(posedge clk); #1;
      mt_hi = 1'b0;
      mt_lo = 1'b0;
      check("mt both hi", hi, 32'hCAFE_F00D);
      check("mt both lo", lo, 32'hCAFE_F00D);

      // MTLO together with start: the start wins and LO is not written.
      mt_lo   = 1'b1;
      mt_data = 32'hDEAD_0000;
      op      = OP_MULTU;
      rs_data = 32'd2;
      rt_data = 32'd2;
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      mt_lo = 1'b0;
      check("mtlo with start ignored", lo, 32'hCAFE_F00D);
      check("mtlo with start busy", 32'(busy), 32'd1);
      begin
         int lat;
         lat = 0;
         for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done) begin
               lat = n;
               break;
            end
         end
         check("start+mtlo latency", lat, 32'd32);
      end
      check("start+mtlo hi", hi, 32'd0);
      check("start+mtlo lo", lo, 32'd4);

      // Reset asserted between edges 10 and 11 of a MULTU.
      op      = OP_MULTU;
      rs_data = 32'hFFFF_FFFF;
      rt_data = 32'hFFFF_FFFF;
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("mid reset busy", 32'(busy), 32'd0);
      check("mid reset hi", hi, 32'd0);
      check("mid reset lo", lo, 32'd0);
      begin
         logic saw_done;
         saw_done = 1'b0;
         repeat (3) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
         end
         @(negedge clk);
         rst = 1'b0;
         repeat (30) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
         end
         check("no done after abort", 32'(saw_done), 32'd0);
      end
      run_op(OP_MULTU, 32'h1234_5678, 32'h10, 0, 0, "after reset");
      check("after reset hi", hi, 32'd1);
      check("after reset lo", lo, 32'h2345_6780);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit with HI/LO registers for the MIPS datapath. Sits downstream of the register bank: it consumes the two register read-data operands (rs, rt) for MULT, MULTU, DIV and DIVU. It holds the 64-bit result in HI/LO, which feeds the MFHI/MFLO write-back path into the register bank's WriteData. The control unit stalls on `busy`.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width; the iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a new operation; sampled only while `busy`=0.
- `op`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_data`  in  WIDTH  operand A (multiplicand or dividend), from register bank ReadData1.
- `rt_data`  in  WIDTH  operand B (multiplier or divisor), from register bank ReadData2.
- `mt_hi`  in  1  MTHI: write `mt_data` into HI.
- `mt_lo`  in  1  MTLO: write `mt_data` into LO.
- `mt_data`  in  WIDTH  data for MTHI/MTLO.
- `busy`  out  1  an operation is in progress.
- `done`  out  1  one-cycle pulse marking the cycle in which HI/LO first hold a new result.
- `hi`  out  WIDTH  HI register: product upper half, or remainder.
- `lo`  out  WIDTH  LO register: product lower half, or quotient.

## Operation
- States: IDLE and CALC.
- IDLE:
  - `start`=1 latches operands, `op` and sign information, clears the iteration counter and moves to CALC.
  - `start`=0 stays in IDLE.
- CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. After `WIDTH` steps the unit:
  - writes HI/LO;
  - pulses `done`;
  - returns to IDLE.
- Signed ops (MULT, DIV) work on magnitudes, latched at start, then sign-correct the result:
  - product is negated if the operand signs differ;
  - quotient is negated if the operand signs differ;
  - remainder takes the sign of the dividend;
  - quotient truncates toward zero.
- Multiply result: full 2·WIDTH-bit product; `hi` gets the upper half, `lo` the lower half.
- Divide by zero (`rt_data`=0, any signedness): `lo`=all-ones, `hi`=`rs_data`, with normal latency.
- Signed overflow (DIV, -2^31 / -1): `lo`=32'h8000_0000, `hi`=0.
- MTHI/MTLO:
  - applied at the edge only when `busy`=0 and `start`=0; otherwise ignored;
  - both may be asserted together, in which case both registers are written.
- `start` while `busy`=1 is ignored; there is no queueing.
- HI/LO hold their value until the next `done` or MT write; partial results are never visible on `hi`/`lo`.

## Timing
- Reset values: state IDLE; `busy`=0; `done`=0; `hi`=0; `lo`=0; counter 0.
- Reset asserted mid-CALC aborts the operation immediately (asynchronous). HI/LO go to 0 and no `done` is produced.
- Sequence for `start` sampled at edge k:
  - `busy`=1 after edge k;
  - at edge k+WIDTH (k+32): `busy`→0, `done`→1, and HI/LO carry the result;
  - at edge k+33: `done`→0.
- Latency is fixed at 32 cycles for every op and operand value; there is no early termination.
- Back-to-back operation: `start` is accepted in the cycle where `done`=1 because `busy`=0 there. The next result follows 32 cycles later.
- Operands are needed only in the `start` cycle. `rs_data`/`rt_data` may change afterwards with no effect.
- `busy` and `done` are registered outputs with no combinational path from inputs.

## Test plan
- Reset then MULTU, rs=32'hFFFF_FFFF, rt=32'hFFFF_FFFF -> `done` exactly 32 cycles after start; hi=32'hFFFF_FFFE, lo=32'h0000_0001; `busy` high for 32 cycles.
- MULT, rs=-7 (32'hFFFF_FFF9), rt=3 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB (-21).
- DIV, rs=-7, rt=2 -> lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1). DIVU, rs=100, rt=7 -> lo=14, hi=2.
- Boundary cases:
  - DIVU, rs=5, rt=0 -> lo=32'hFFFF_FFFF, hi=5;
  - DIV, rs=32'h8000_0000, rt=32'hFFFF_FFFF -> lo=32'h8000_0000, hi=0.
- Handshake:
  - `start` pulsed mid-CALC with new operands -> ignored, the original result is delivered;
  - `start` in the `done` cycle -> accepted, second `done` 32 cycles later;
  - `mt_hi`=1 with mt_data=32'h1234_5678 during `busy` -> hi unchanged;
  - same request while idle -> hi=32'h1234_5678 next edge.
- Reset asserted at cycle 10 of a MULTU -> `busy`=0, hi=lo=0 immediately, no `done` pulse. A new op after release completes normally.
